// File: rtl/countdown_timer_if.sv
// countdown_timer_if -- front-panel bundle for the countdown timer.
//   sw_i        [7:0] preset value, sampled on a LOAD press event
//   btn_load_i        raw bouncing LOAD pushbutton, active-high
//   btn_start_i       raw bouncing START/PAUSE pushbutton, active-high
//   tick_i            one-cycle 1 Hz strobe, synchronous to mclk
//   led_o       [7:0] count value, or blink pattern while expired
//   done_o            high while expired
interface countdown_timer_if;
   logic [7:0] sw_i;
   logic       btn_load_i;
   logic       btn_start_i;
   logic       tick_i;
   logic [7:0] led_o;
   logic       done_o;

   modport slave (
      input  sw_i, btn_load_i, btn_start_i, tick_i,
      output led_o, done_o
   );

   modport master (
      output sw_i, btn_load_i, btn_start_i, tick_i,
      input  led_o, done_o
   );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer -- 8-bit seconds countdown with debounced LOAD and
// START/PAUSE buttons and a blinking expiry indication.
//   mclk  system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   countdown_timer_if.slave (switches, buttons, tick, LED, DONE)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | count loaded (or zero), waiting for START
// RUN     | counting down on each tick
// PAUSE   | count held, START resumes
// EXPIRED | count reached zero, LEDs blink on each tick
module countdown_timer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic             mclk,
   input  logic             rst_n,
   countdown_timer_if.slave bus
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DB_RELOAD = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   // Button front end; bit 0 = LOAD, bit 1 = START.
   logic [1:0]         btn_raw;
   logic [1:0]         meta_q;
   logic [1:0]         sync_q;
   logic [1:0]         level_q, level_d;
   logic [1:0]         level_prev_q;
   logic [1:0][CW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]         press;

   assign btn_raw = {bus.btn_start_i, bus.btn_load_i};

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q       <= '0;
         sync_q       <= '0;
         level_q      <= '0;
         level_prev_q <= '0;
         db_cnt_q     <= '0;
      end else begin
         meta_q       <= btn_raw;
         sync_q       <= meta_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         db_cnt_q     <= db_cnt_d;
      end
   end

   // Down-counter reloads whenever the input agrees with the debounced level,
   // so the level only flips after DEBOUNCE_CYCLES consecutive disagreeing cycles.
   always_comb begin
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync_q[i] == level_q[i]) begin
            db_cnt_d[i] = DB_RELOAD;
         end else if (db_cnt_q[i] == '0) begin
            level_d[i]  = sync_q[i];
            db_cnt_d[i] = DB_RELOAD;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] - 1'b1;
         end
      end
   end

   assign press = level_q & ~level_prev_q;

   // Timer core.
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       blink_q, blink_d;
   logic [7:0] led_q, led_d;
   logic       done_q, done_d;
   logic       load_ev, start_ev;

   assign load_ev  = press[0];
   assign start_ev = press[1];

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'h00;
         blink_q <= 1'b0;
         led_q   <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
         led_q   <= led_d;
         done_q  <= done_d;
      end
   end

   // Events are mutually exclusive by priority: LOAD, then START, then TICK.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blink_d = blink_q;
      if (load_ev) begin
         cnt_d   = bus.sw_i;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_ev && (cnt_q != 8'h00)) state_d = RUN;
            end
            RUN: begin
               if (start_ev) begin
                  state_d = PAUSE;
               end else if (bus.tick_i) begin
                  if (cnt_q > 8'd1) begin
                     cnt_d = cnt_q - 8'd1;
                  end else begin
                     cnt_d   = 8'h00;
                     state_d = EXPIRED;
                     blink_d = 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (start_ev) state_d = RUN;
            end
            EXPIRED: begin
               if (bus.tick_i) blink_d = ~blink_q;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are derived from next-state values so they register with the state.
   always_comb begin
      done_d = (state_d == EXPIRED);
      led_d  = done_d ? {8{blink_d}} : cnt_d;
   end

   assign bus.led_o  = led_q;
   assign bus.done_o = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

   logic mclk;
   logic rst_n;
   int   total;
   int   bad;

   countdown_timer_if bus ();

   countdown_timer #(.DEBOUNCE_CYCLES(4)) dut (
      .mclk  (mclk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge mclk);
      bus.tick_i = 1'b1;
      @(negedge mclk);
      bus.tick_i = 1'b0;
   endtask

   // Press event reaches the FSM 7 edges after the button rises (2 sync + 4 debounce
   // + 1 edge detect); with_tick places a TICK on exactly that edge.
   task automatic press(input bit ld, input bit st, input bit with_tick);
      @(negedge mclk);
      bus.btn_load_i  = ld;
      bus.btn_start_i = st;
      repeat (6) @(negedge mclk);
      if (with_tick) bus.tick_i = 1'b1;
      @(negedge mclk);
      bus.tick_i = 1'b0;
      repeat (4) @(negedge mclk);
      bus.btn_load_i  = 1'b0;
      bus.btn_start_i = 1'b0;
      repeat (10) @(negedge mclk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n           = 1'b0;
      bus.sw_i        = 8'h00;
      bus.btn_load_i  = 1'b0;
      bus.btn_start_i = 1'b0;
      bus.tick_i      = 1'b0;
      #23;
      check("rst_led", bus.led_o, 8'h00);
      check("rst_done", {7'b0, bus.done_o}, 8'h00);
      @(negedge mclk);
      rst_n = 1'b1;
      repeat (2) @(negedge mclk);

      // Bouncing LOAD, then held
      bus.sw_i = 8'h03;
      for (int k = 0; k < 3; k++) begin
         bus.btn_load_i = 1'b1;
         repeat (2) @(negedge mclk);
         bus.btn_load_i = 1'b0;
         repeat (2) @(negedge mclk);
      end
      repeat (3) @(negedge mclk);
      check("bounce_no_event", bus.led_o, 8'h00);
      bus.btn_load_i = 1'b1;
      repeat (12) @(negedge mclk);
      check("load3_led", bus.led_o, 8'h03);
      check("load3_done", {7'b0, bus.done_o}, 8'h00);
      bus.sw_i = 8'hAA;
      repeat (10) @(negedge mclk);
      check("held_one_event", bus.led_o, 8'h03);
      bus.btn_load_i = 1'b0;
      repeat (10) @(negedge mclk);

      // Count down to expiry and blink
      press(0, 1, 0);
      check("start_led", bus.led_o, 8'h03);
      do_tick(); check("run_t1", bus.led_o, 8'h02);
      do_tick(); check("run_t2", bus.led_o, 8'h01);
      do_tick(); check("exp_led", bus.led_o, 8'hFF);
      check("exp_done", {7'b0, bus.done_o}, 8'h01);
      press(0, 1, 0);
      check("exp_start_ign", bus.led_o, 8'hFF);
      check("exp_start_done", {7'b0, bus.done_o}, 8'h01);
      do_tick(); check("blink_off", bus.led_o, 8'h00);
      check("blink_off_done", {7'b0, bus.done_o}, 8'h01);
      do_tick(); check("blink_on", bus.led_o, 8'hFF);

      // Pause / resume
      bus.sw_i = 8'h05;
      press(1, 0, 0);
      check("load5_led", bus.led_o, 8'h05);
      check("load5_done", {7'b0, bus.done_o}, 8'h00);
      press(0, 1, 0);
      do_tick(); check("run5_t1", bus.led_o, 8'h04);
      press(0, 1, 0);
      for (int k = 0; k < 3; k++) begin
         do_tick();
         check("pause_hold", bus.led_o, 8'h04);
      end
      press(0, 1, 0);
      do_tick(); check("resume_t1", bus.led_o, 8'h03);

      // LOAD + START + TICK in one cycle
      bus.sw_i = 8'h05;
      press(1, 0, 0);
      press(0, 1, 0);
      do_tick(); check("pre_coinc", bus.led_o, 8'h04);
      bus.sw_i = 8'h10;
      press(1, 1, 1);
      check("coinc_load", bus.led_o, 8'h10);
      check("coinc_done", {7'b0, bus.done_o}, 8'h00);
      do_tick(); check("coinc_idle", bus.led_o, 8'h10);

      // START + TICK in one cycle while running
      press(0, 1, 0);
      do_tick(); check("run10_t1", bus.led_o, 8'h0F);
      press(0, 1, 1);
      check("start_beats_tick", bus.led_o, 8'h0F);
      do_tick(); check("paused_0f", bus.led_o, 8'h0F);

      // Zero load: START ignored
      bus.sw_i = 8'h00;
      press(1, 0, 0);
      check("load0_led", bus.led_o, 8'h00);
      press(0, 1, 0);
      do_tick(); check("zero_tick", bus.led_o, 8'h00);
      check("zero_done", {7'b0, bus.done_o}, 8'h00);
      bus.sw_i = 8'h02;
      press(1, 0, 0);
      do_tick(); check("zero_stayed_idle", bus.led_o, 8'h02);

      // Asynchronous reset mid-count
      bus.sw_i = 8'h07;
      press(1, 0, 0);
      press(0, 1, 0);
      check("pre_rst_led", bus.led_o, 8'h07);
      @(negedge mclk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_led", bus.led_o, 8'h00);
      check("async_rst_done", {7'b0, bus.done_o}, 8'h00);
      #13 rst_n = 1'b1;
      do_tick(); check("post_rst_t1", bus.led_o, 8'h00);
      do_tick(); check("post_rst_t2", bus.led_o, 8'h00);
      press(0, 1, 0);
      do_tick(); check("post_rst_start", bus.led_o, 8'h00);

      // LOAD held through reset release
      bus.sw_i = 8'h22;
      @(negedge mclk);
      bus.btn_load_i = 1'b1;
      repeat (3) @(negedge mclk);
      #2 rst_n = 1'b0;
      #10 rst_n = 1'b1;
      check("held_rst_led", bus.led_o, 8'h00);
      repeat (12) @(negedge mclk);
      check("held_rst_event", bus.led_o, 8'h22);
      bus.btn_load_i = 1'b0;
      repeat (10) @(negedge mclk);
      check("held_rst_final", bus.led_o, 8'h22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable MCLK cycles (10 ms at 50 MHz) before a button level is accepted; SHALL be ≥2.
REQ-002 MCLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset (RESET=0 resets).
REQ-004 SW  input  8  preset value, sampled only on a LOAD press event.
REQ-005 BTN_LOAD  input  1  raw, asynchronous, bouncing pushbutton, active-high.
REQ-006 BTN_START  input  1  raw, asynchronous, bouncing pushbutton, active-high; toggles run/pause.
REQ-007 TICK  input  1  one-MCLK-wide 1 Hz strobe from the team's pulse generator, synchronous to MCLK.
REQ-008 LED  output  8  count value or expiry blink pattern.
REQ-009 DONE  output  1  high while the timer is expired.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its debounced level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the stability count.
REQ-011 A press event SHALL be a one-cycle pulse on the 0->1 transition of the debounced level; releases generate no event; a held button generates exactly one event.
REQ-012 State machine SHALL have states IDLE, RUN, PAUSE, EXPIRED; 8-bit count register CNT.
REQ-013 LOAD event in any state: CNT <= SW, next state IDLE.
REQ-014 IDLE: START event with CNT != 0 -> RUN; START event with CNT == 0 -> no action; TICK ignored.
REQ-015 RUN: TICK with CNT > 1 -> CNT-1; TICK with CNT == 1 -> CNT <= 0 and next state EXPIRED; START event -> PAUSE.
REQ-016 PAUSE: TICK ignored, CNT held; START event -> RUN.
REQ-017 EXPIRED: START and CNT held; START events ignored; BLINK flag toggles on every TICK.
REQ-018 Priority on simultaneous events in one cycle: LOAD > START > TICK; a TICK coincident with a winning START or LOAD event SHALL be discarded (no decrement).
REQ-019 CNT SHALL never wrap below 0; no decrement occurs outside RUN.
REQ-020 BLINK SHALL be set to 1 on the cycle EXPIRED is entered.
REQ-021 LED = CNT in IDLE/RUN/PAUSE; LED = {8{BLINK}} in EXPIRED.
REQ-022 DONE = 1 exactly when state is EXPIRED.
REQ-023 LED and DONE SHALL be registered; effects of an event or TICK SHALL be visible on LED/DONE on the first rising edge after the edge on which the event/TICK is sampled (1-cycle latency).
REQ-024 Button-to-event latency SHALL be 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 cycle edge detection, ±1 cycle.

Reset
REQ-025 RESET=0 SHALL asynchronously force: state IDLE, CNT=0x00, BLINK=0, LED=0x00, DONE=0, debounced levels=0, stability counters=0, synchronizers=0.
REQ-026 RESET asserted mid-count SHALL abandon the count; after release the block SHALL sit in IDLE with LED=0x00 until a LOAD event.
REQ-027 A button held through reset release SHALL produce one press event after debounce (debounced level starts at 0).

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-028 SW=0x03, bounce BTN_LOAD 3 times <4 cycles each then hold -> exactly one LOAD event; LED=0x03, DONE=0.
REQ-029 After REQ-028, START press, 3 TICKs -> LED 0x02, 0x01, then DONE=1 and LED=0xFF; next TICK -> LED=0x00; next TICK -> LED=0xFF.
REQ-030 SW=0x05 loaded, RUN, 1 TICK (LED=0x04), START press, 3 TICKs -> LED stays 0x04; START press, 1 TICK -> LED=0x03.
REQ-031 In RUN with LED=0x04, LOAD and START events and TICK in same cycle with SW=0x10 -> state IDLE, LED=0x10, no decrement.
REQ-032 LOAD with SW=0x00 then START -> remains IDLE, LED=0x00, DONE=0, TICKs have no effect.
REQ-033 In RUN at LED=0x07, pulse RESET low for a time not aligned to MCLK -> LED=0x00, DONE=0 immediately; after release, TICKs cause no change.
